// File: rtl/layer_link_pkg.sv
// Shared types and default constants for the layer-to-layer serial link receiver.
// Holds the link FSM state encoding, default word widths/count and the
// saturation limits used when narrowing at the default output width.
package layer_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        FIN    = 3'd4
    } state_e;

    localparam int unsigned DEF_IN_WIDTH  = 20;
    localparam int unsigned DEF_OUT_WIDTH = 17;
    localparam int unsigned DEF_NPREV     = 30;
    localparam int unsigned DEF_CNT_WIDTH = 6;

    // Signed limits of a DEF_OUT_WIDTH-bit word (two's complement bit patterns)
    localparam logic [DEF_OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
    localparam logic [DEF_OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed narrowing from IN_WIDTH to OUT_WIDTH bits (LSB-aligned).
// Build option: LAYER_LINK_SAT_EN -> clamp to the signed output range;
// otherwise keep the low OUT_WIDTH bits (wrap).
// Ports: din (IN_WIDTH, signed), dout_c (OUT_WIDTH, signed).
module sat_narrow #(
    parameter int unsigned IN_WIDTH  = 20,
    parameter int unsigned OUT_WIDTH = 17
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout_c
);

`ifdef LAYER_LINK_SAT_EN
    localparam int unsigned HI_W = IN_WIDTH - OUT_WIDTH + 1;
    localparam logic [OUT_WIDTH-1:0] LIM_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] LIM_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [HI_W-1:0] hi;

    // Value fits when the dropped bits plus the new sign bit are all equal
    always_comb begin
        hi = din[IN_WIDTH-1:OUT_WIDTH-1];
        if ((hi == '0) || (hi == '1)) begin
            dout_c = din[OUT_WIDTH-1:0];
        end else if (din[IN_WIDTH-1]) begin
            dout_c = LIM_MIN;
        end else begin
            dout_c = LIM_MAX;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^din[IN_WIDTH-1:OUT_WIDTH];
    assign dout_c    = din[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/layer_link_rx.sv
// Receiving end of an upstream layer's serial (PISO) output. Shifts NPREV words
// out of the upstream layer into a local buffer, starts the next layer, streams
// the narrowed words into it one per cycle (honouring next_hold), then pulses
// done and restarts the upstream layer.
// Build option: LAYER_LINK_SAT_EN selects saturating narrowing (see sat_narrow).
// Ports:
//   clk, rst (sync, active-high)
//   upstream : prev_finished, prev_sout, prev_transferred -> shift_out, restart_out
//   next     : next_ready, next_hold -> next_start, next_data, next_valid
//   status   : done (pulse), underrun_err (sticky until rst)
module layer_link_rx #(
    parameter int unsigned IN_WIDTH  = layer_link_pkg::DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = layer_link_pkg::DEF_OUT_WIDTH,
    parameter int unsigned NPREV     = layer_link_pkg::DEF_NPREV,
    parameter int unsigned CNT_WIDTH = layer_link_pkg::DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prev_finished,
    input  logic [IN_WIDTH-1:0]  prev_sout,
    input  logic                 prev_transferred,
    output logic                 shift_out,
    output logic                 restart_out,
    input  logic                 next_ready,
    input  logic                 next_hold,
    output logic                 next_start,
    output logic [OUT_WIDTH-1:0] next_data,
    output logic                 next_valid,
    output logic                 done,
    output logic                 underrun_err
);
    import layer_link_pkg::*;

    localparam int unsigned DEPTH = 2 ** CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NPREV - 1);

    state_e                state_q, state_d;
    logic                  shift_out_q, shift_out_d;
    logic                  restart_out_q, restart_out_d;
    logic                  next_start_q, next_start_d;
    logic                  next_valid_q, next_valid_d;
    logic [OUT_WIDTH-1:0]  next_data_q, next_data_d;
    logic                  done_q, done_d;
    logic                  underrun_err_q, underrun_err_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic                  buf_we;
    logic [IN_WIDTH-1:0]   buf_mem [DEPTH];
    logic [IN_WIDTH-1:0]   rd_word;
    logic [OUT_WIDTH-1:0]  narrow_c;

    // wr_cnt doubles as the fill level: entries never captured read as zero
    assign rd_word = (rd_cnt_q < wr_cnt_q) ? buf_mem[rd_cnt_q] : '0;

    sat_narrow #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_narrow (
        .din    (rd_word),
        .dout_c (narrow_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        shift_out_d    = shift_out_q;
        restart_out_d  = 1'b0;
        next_start_d   = 1'b0;
        next_valid_d   = 1'b0;
        next_data_d    = next_data_q;
        done_d         = 1'b0;
        underrun_err_d = underrun_err_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        buf_we         = 1'b0;

        case (state_q)
            IDLE: begin
                // restart_out_q high means upstream has not yet seen its restart
                if (prev_finished && !restart_out_q) begin
                    state_d     = SHIFT;
                    shift_out_d = 1'b1;
                    wr_cnt_d    = '0;
                end
            end
            SHIFT: begin
                if (prev_transferred && (wr_cnt_q < LAST_IDX)) begin
                    underrun_err_d = 1'b1;
                    shift_out_d    = 1'b0;
                    state_d        = WAIT;
                end else begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        shift_out_d = 1'b0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (next_ready) begin
                    next_start_d = 1'b1;
                    rd_cnt_d     = '0;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (!next_hold) begin
                    next_valid_d = 1'b1;
                    next_data_d  = narrow_c;
                    rd_cnt_d     = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_d        = 1'b1;
                restart_out_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_out_q    <= 1'b0;
            restart_out_q  <= 1'b0;
            next_start_q   <= 1'b0;
            next_valid_q   <= 1'b0;
            next_data_q    <= '0;
            done_q         <= 1'b0;
            underrun_err_q <= 1'b0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            shift_out_q    <= shift_out_d;
            restart_out_q  <= restart_out_d;
            next_start_q   <= next_start_d;
            next_valid_q   <= next_valid_d;
            next_data_q    <= next_data_d;
            done_q         <= done_d;
            underrun_err_q <= underrun_err_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
        end
    end

    // Word buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_cnt_q] <= prev_sout;
        end
    end

    assign shift_out    = shift_out_q;
    assign restart_out  = restart_out_q;
    assign next_start   = next_start_q;
    assign next_valid   = next_valid_q;
    assign next_data    = next_data_q;
    assign done         = done_q;
    assign underrun_err = underrun_err_q;

endmodule

// File: tb/tb_layer_link_rx.sv
// Bench for layer_link_rx with NPREV=4: upstream PISO model, scoreboard queue of
// expected streamed words, and a negedge monitor that pops and compares.
module tb_layer_link_rx;

    localparam int unsigned IN_W  = 20;
    localparam int unsigned OUT_W = 17;
    localparam int unsigned NP    = 4;
    localparam int unsigned CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             prev_finished;
    logic [IN_W-1:0]  prev_sout;
    logic             prev_transferred;
    logic             shift_out;
    logic             restart_out;
    logic             next_ready;
    logic             next_hold;
    logic             next_start;
    logic [OUT_W-1:0] next_data;
    logic             next_valid;
    logic             done;
    logic             underrun_err;

    layer_link_rx #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .NPREV     (NP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .prev_finished    (prev_finished),
        .prev_sout        (prev_sout),
        .prev_transferred (prev_transferred),
        .shift_out        (shift_out),
        .restart_out      (restart_out),
        .next_ready       (next_ready),
        .next_hold        (next_hold),
        .next_start       (next_start),
        .next_data        (next_data),
        .next_valid       (next_valid),
        .done             (done),
        .underrun_err     (underrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [IN_W-1:0]  up_words [NP];
    int               up_idx = 0;
    logic [OUT_W-1:0] exp_q [$];

    int shift_cnt = 0, start_cnt = 0, done_cnt = 0, restart_cnt = 0, valid_cnt = 0;
    int start_cyc = 0;
    bit await_first = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream PISO: places the next word on the falling edge while shift_out=1
    always @(negedge clk) begin
        if (!shift_out) begin
            up_idx = 0;
        end else if (up_idx < int'(NP)) begin
            prev_sout = up_words[up_idx];
            up_idx++;
        end
    end

    // Monitor: pulse counters and scoreboard comparison of streamed words
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_out)   shift_cnt++;
            if (restart_out) restart_cnt++;
            if (next_start) begin
                start_cnt++;
                start_cyc   = cyc;
                await_first = 1;
            end
            if (done) begin
                done_cnt++;
                chk("done_restart_valid", {restart_out, next_valid}, 2'b10);
            end
            if (next_valid) begin
                valid_cnt++;
                if (await_first) begin
                    chk("start_to_valid", cyc - start_cyc, 1);
                    await_first = 0;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got data 0x%0h, expected no word", next_data);
                end else begin
                    chk("next_data", next_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load upstream words, queue expectations, pulse prev_finished for one cycle
    task automatic xfer_start(input logic [IN_W-1:0] w [NP], input logic [OUT_W-1:0] e [NP],
                              input bit push);
        for (int i = 0; i < int'(NP); i++) begin
            up_words[i] = w[i];
            if (push) exp_q.push_back(e[i]);
        end
        prev_finished = 1'b1;
        tick();
        prev_finished = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base = done_cnt;
        int n    = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == base) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", budget);
        end
    endtask

    logic [IN_W-1:0]  w_a [NP];
    logic [OUT_W-1:0] e_a [NP];
    int b_shift, b_start, b_done, b_restart, b_valid, ready_cyc, n;

    task automatic snap();
        b_shift   = shift_cnt;
        b_start   = start_cnt;
        b_done    = done_cnt;
        b_restart = restart_cnt;
        b_valid   = valid_cnt;
    endtask

    task automatic chk_counts(input string tag, input int sh);
        chk({tag, "_shift_cycles"}, shift_cnt - b_shift, sh);
        chk({tag, "_start_pulses"}, start_cnt - b_start, 1);
        chk({tag, "_valid_words"}, valid_cnt - b_valid, NP);
        chk({tag, "_done_pulses"}, done_cnt - b_done, 1);
        chk({tag, "_restart_pulses"}, restart_cnt - b_restart, 1);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; prev_finished = 1'b0; prev_sout = '0; prev_transferred = 1'b0;
        next_ready = 1'b0; next_hold = 1'b0;
        repeat (3) tick();
        chk("rst_shift_out", shift_out, 0);
        chk("rst_restart_out", restart_out, 0);
        chk("rst_next_start", next_start, 0);
        chk("rst_next_valid", next_valid, 0);
        chk("rst_next_data", next_data, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun_err, 0);
        rst = 1'b0;
        tick();

        // Basic transfer 1,2,3,4
        next_ready = 1'b1;
        w_a = '{20'd1, 20'd2, 20'd3, 20'd4};
        e_a = '{17'd1, 17'd2, 17'd3, 17'd4};
        snap();
        xfer_start(w_a, e_a, 1);
        wait_done(60);
        chk_counts("basic", 4);

        // Two-cycle hold after the second streamed word
        snap();
        xfer_start(w_a, e_a, 1);
        n = 0;
        while (!(next_valid && next_data == 17'd2) && n < 40) begin
            tick();
            n++;
        end
        chk("hold_reached_word2", {next_valid, next_data}, {1'b1, 17'd2});
        next_hold = 1'b1;
        tick();
        chk("hold1_valid_data", {next_valid, next_data}, {1'b0, 17'd2});
        tick();
        chk("hold2_valid_data", {next_valid, next_data}, {1'b0, 17'd2});
        next_hold = 1'b0;
        wait_done(60);
        chk_counts("hold", 4);

        // Narrowing of extreme values
        w_a = '{20'h7FFFF, 20'h80000, 20'h00001, 20'hFFFFF};
`ifdef LAYER_LINK_SAT_EN
        e_a = '{17'h0FFFF, 17'h10000, 17'h00001, 17'h1FFFF};
`else
        e_a = '{17'h1FFFF, 17'h00000, 17'h00001, 17'h1FFFF};
`endif
        snap();
        xfer_start(w_a, e_a, 1);
        wait_done(60);
        chk_counts("narrow", 4);

        // Underrun: prev_transferred after two captures
        w_a = '{20'd9, 20'd10, 20'd11, 20'd12};
        e_a = '{17'd9, 17'd10, 17'd0, 17'd0};
        snap();
        xfer_start(w_a, e_a, 1);
        tick();
        tick();
        prev_transferred = 1'b1;
        wait_done(60);
        prev_transferred = 1'b0;
        chk_counts("underrun", 3);
        repeat (5) tick();
        chk("underrun_sticky", underrun_err, 1);

        // Reset mid-SHIFT after two captures, then a clean transfer
        w_a = '{20'd1, 20'd2, 20'd3, 20'd4};
        e_a = '{17'd1, 17'd2, 17'd3, 17'd4};
        snap();
        xfer_start(w_a, e_a, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_shift_out", shift_out, 0);
        chk("abort_next_data", next_data, 0);
        chk("abort_underrun", underrun_err, 0);
        chk("abort_flags", {restart_out, next_start, next_valid, done}, 4'b0000);
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_restart", restart_cnt - b_restart, 0);
        snap();
        xfer_start(w_a, e_a, 1);
        wait_done(60);
        chk_counts("after_abort", 4);

        // next_ready held low for 10 cycles after capture
        next_ready = 1'b0;
        w_a = '{20'h11, 20'h22, 20'h33, 20'h44};
        e_a = '{17'h11, 17'h22, 17'h33, 17'h44};
        snap();
        xfer_start(w_a, e_a, 1);
        n = 0;
        while (shift_out && n < 20) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("no_start_while_not_ready", start_cnt - b_start, 0);
        chk("no_valid_while_not_ready", valid_cnt - b_valid, 0);
        next_ready = 1'b1;
        ready_cyc  = cyc;
        wait_done(60);
        chk("ready_to_start_le1", (start_cyc - ready_cyc) <= 1, 1);
        chk_counts("late_ready", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
